// File: rtl/tdc_pulse_pair_gen_if.sv
// Control and strobe bundle of the TDC START/STOP pulse-pair generator.
// Outputs come straight from registers in the generator; there is no backpressure.
interface tdc_pulse_pair_gen_if #(
  parameter int DELAY_W = 8,
  parameter int BURST_W = 4
);
  logic               trigger;
  logic               abort;
  logic [DELAY_W-1:0] delay_code;
  logic [BURST_W-1:0] burst_len;
  logic               start_pulse;
  logic               stop_pulse;
  logic               busy;
  logic               done;
  logic [BURST_W:0]   pairs_sent;

  modport master (
    output trigger, abort, delay_code, burst_len,
    input  start_pulse, stop_pulse, busy, done, pairs_sent
  );

  modport slave (
    input  trigger, abort, delay_code, burst_len,
    output start_pulse, stop_pulse, busy, done, pairs_sent
  );
endinterface

// File: rtl/tdc_pulse_pair_gen.sv
// Emits START, then STOP delay_code cycles later, repeated burst_len+1 times with a fixed gap.
// START lags the trigger edge by one cycle; triggers arriving while busy are dropped, not queued.
module tdc_pulse_pair_gen #(
  parameter int DELAY_W    = 8,
  parameter int BURST_W    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdc_pulse_pair_gen_if.slave  bus
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("tdc_pulse_pair_gen: GAP_CYCLES must be in 1..255");
  end

  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [DELAY_W-1:0] r_delay, w_delay_nxt;
  logic [DELAY_W-1:0] r_cnt, w_cnt_nxt;
  logic [BURST_W:0]   r_n, w_n_nxt;
  logic [BURST_W:0]   r_pairs, w_pairs_nxt;
  logic [7:0]         r_gcnt, w_gcnt_nxt;
  logic               r_start, w_start_nxt;
  logic               r_stop, w_stop_nxt;
  logic               r_done, w_done_nxt;
  logic               w_launch;
  logic [DELAY_W-1:0] w_ld_delay;

  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay;
    w_cnt_nxt   = r_cnt;
    w_n_nxt     = r_n;
    w_pairs_nxt = r_pairs;
    w_gcnt_nxt  = r_gcnt;
    w_start_nxt = 1'b0;
    w_stop_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_launch    = 1'b0;
    w_ld_delay  = r_delay;

    case (r_state)
      IDLE: begin
        // The done cycle still blocks a launch so back-to-back sequences are spaced by two cycles.
        if (bus.trigger && !bus.abort && !r_done) begin
          w_launch    = 1'b1;
          w_ld_delay  = bus.delay_code;
          w_delay_nxt = bus.delay_code;
          w_n_nxt     = {1'b0, bus.burst_len} + {{BURST_W{1'b0}}, 1'b1};
          w_pairs_nxt = '0;
        end
      end
      START, WAIT: begin
        // r_cnt == 0 marks the cycle in which the STOP strobe is on the output.
        if (r_cnt == '0) begin
          if (r_pairs == r_n) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (GAP_CYCLES == 1) begin
            w_launch = 1'b1;
          end else begin
            w_state_nxt = GAP;
            w_gcnt_nxt  = GAP_LD;
          end
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = r_cnt - 1'b1;
          if (r_cnt == DELAY_W'(1)) begin
            w_stop_nxt  = 1'b1;
            w_pairs_nxt = r_pairs + 1'b1;
          end
        end
      end
      GAP: begin
        if (r_gcnt == 8'd1) w_launch = 1'b1;
        else                w_gcnt_nxt = r_gcnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_launch) begin
      w_state_nxt = START;
      w_start_nxt = 1'b1;
      w_cnt_nxt   = w_ld_delay;
      if (w_ld_delay == '0) begin
        w_stop_nxt  = 1'b1;
        w_pairs_nxt = w_pairs_nxt + 1'b1;
      end
    end

    // Abort wins over everything, including a STOP due on this edge.
    if (bus.abort && r_state != IDLE) begin
      w_state_nxt = IDLE;
      w_start_nxt = 1'b0;
      w_stop_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_pairs_nxt = r_pairs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_delay <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_pairs <= '0;
      r_gcnt  <= '0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_delay <= w_delay_nxt;
      r_cnt   <= w_cnt_nxt;
      r_n     <= w_n_nxt;
      r_pairs <= w_pairs_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_start <= w_start_nxt;
      r_stop  <= w_stop_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.start_pulse = r_start;
  assign bus.stop_pulse  = r_stop;
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.pairs_sent  = r_pairs;

endmodule

// File: doc/tdc_pulse_pair_gen.md
Name: tdc_pulse_pair_gen

Overview:
- Digital stimulus source for the TDC: generates a START edge, then a STOP edge a programmed number of clock cycles later, optionally as a burst of identical pairs.
- The TDC converts a START/STOP interval into a code; this block converts a code into a START/STOP interval.
- Drives the TDC START/STOP inputs for on-chip self-test and calibration, replacing external pulse equipment.

Parameters:
- DELAY_W, 8, width of the delay code in clock cycles.
- BURST_W, 4, width of the burst-length field.
- GAP_CYCLES, 4, cycles from a STOP to the next START within a burst; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  active-low asynchronous reset.
- trigger  input  1  synchronous level; a sample of 1 in IDLE launches a sequence.
- abort  input  1  synchronous; terminates the sequence in progress.
- delay_code  input  DELAY_W  number of clock cycles from START to STOP; latched at trigger.
- burst_len  input  BURST_W  number of pairs minus 1; latched at trigger.
- start_pulse  output  1  one-cycle registered START strobe.
- stop_pulse  output  1  one-cycle registered STOP strobe.
- busy  output  1  high while a sequence is active.
- done  output  1  one-cycle strobe after the final STOP.
- pairs_sent  output  BURST_W+1  pairs completed in the current or last sequence.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: start_pulse, stop_pulse, busy, done = 0; pairs_sent = 0; FSM = IDLE; latched registers = 0.
- Reset mid-sequence: all outputs drop immediately (asynchronously). No done is issued.
- Registered outputs: all outputs are registered; none is combinational from an input.
- FSM states: IDLE, START, WAIT, GAP.
- IDLE:
  - trigger=1 at edge k: latch D=delay_code and N=burst_len+1, clear pairs_sent, go to START.
  - Cycle k+1: start_pulse=1 and busy=1.
- START / WAIT:
  - Down-counter loaded with D. stop_pulse is high exactly in cycle (start cycle + D).
  - D=0: start_pulse and stop_pulse are high in the same cycle.
  - Maximum D = 2^DELAY_W-1. The counter never wraps.
- STOP cycle:
  - pairs_sent increments in the same cycle the stop_pulse register goes high.
  - If pairs_sent reaches N: the next cycle has done=1, busy=0, FSM=IDLE.
  - Otherwise go to GAP.
- GAP: the next start_pulse occurs exactly GAP_CYCLES cycles after the stop cycle.
- busy timing: high from the first start cycle through the final stop cycle inclusive.
- trigger while busy: ignored; it is neither queued nor re-latched.
- trigger held high: a new sequence can launch at the first edge in IDLE. The earliest new start is 2 cycles after the previous done.
- Inputs changing mid-sequence: delay_code and burst_len have no effect until the next launch.
- abort=1 while busy at edge j:
  - From cycle j+1: start_pulse=0, stop_pulse=0, busy=0, done=0, FSM=IDLE.
  - pairs_sent holds its value.
  - If abort coincides with the edge that would emit a STOP, that STOP is suppressed.
- abort in IDLE: no effect. abort has priority over a simultaneous trigger.
- Illegal parameter: GAP_CYCLES=0 is illegal and is flagged by an elaboration-time check.

Test Plan:
- Single pair: delay_code=5, burst_len=0, trigger at edge k -> start_pulse at k+1, stop_pulse at k+6, done at k+7, busy high k+1..k+6, pairs_sent=1.
- Zero delay: delay_code=0, burst_len=0 -> start_pulse and stop_pulse both high at k+1, done at k+2. Then delay_code=255 -> stop at k+256, no wrap.
- Burst: delay_code=2, burst_len=2, GAP_CYCLES=4:
  - starts at k+1, k+7, k+13.
  - stops at k+3, k+9, k+15.
  - done at k+16, pairs_sent=3.
- Re-trigger and latch: trigger pulsed at k+3 during the single-pair case, and delay_code changed to 9 at k+2 -> stop still at k+6, exactly one done, no second sequence.
- Abort: burst delay=10, burst_len=3, abort at the edge where the second STOP is due -> no second stop_pulse, busy=0 next cycle, done never asserted, pairs_sent=1.
- Reset mid-operation: rst_n low asynchronously during WAIT -> outputs 0 immediately. After release, trigger with delay=3 -> start and stop 3 cycles apart, pairs_sent restarts at 1.
